// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared region map, one-hot selects and FSM encoding
package bus_pkg;

  localparam logic [7:0] REGION_S0 = 8'h00;
  localparam logic [7:0] REGION_S1 = 8'h01;
  localparam logic [7:0] REGION_S2 = 8'h02;
  localparam logic [7:0] REGION_S3 = 8'h03;
  localparam logic [7:0] REGION_S4 = 8'h04;

  // Bit 4 is s0, bit 0 is s4; matches the downstream select converter.
  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_S0   = 5'b10000;
  localparam logic [4:0] SEL_S1   = 5'b01000;
  localparam logic [4:0] SEL_S2   = 5'b00100;
  localparam logic [4:0] SEL_S3   = 5'b00010;
  localparam logic [4:0] SEL_S4   = 5'b00001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_addr2sel.sv
// rtl/bus_addr2sel.sv - region field to one-hot slave select with valid flag
module bus_addr2sel
  import bus_pkg::*;
#(
  parameter int REGION_W = 8
) (
  input  logic [REGION_W-1:0] i_region,
  output logic [4:0]          o_sel,
  output logic                o_valid
);

  logic [31:0] w_region;

  assign w_region = 32'(i_region);

  always_comb begin
    o_sel   = SEL_NONE;
    o_valid = 1'b0;
    case (w_region)
      32'(REGION_S0): begin o_sel = SEL_S0; o_valid = 1'b1; end
      32'(REGION_S1): begin o_sel = SEL_S1; o_valid = 1'b1; end
      32'(REGION_S2): begin o_sel = SEL_S2; o_valid = 1'b1; end
      32'(REGION_S3): begin o_sel = SEL_S3; o_valid = 1'b1; end
      32'(REGION_S4): begin o_sel = SEL_S4; o_valid = 1'b1; end
      default: begin
        o_sel   = SEL_NONE;
        o_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bus_addrdec.sv
// rtl/bus_addrdec.sv - address decoder and request/ready/timeout sequencer
module bus_addrdec
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [4:0]        s_ready,
  output logic [4:0]        slave_sel,
  output logic              s_wr,
  output logic [7:0]        s_addr,
  output logic              m_done,
  output logic              m_err,
  output logic              busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_sel;
  logic        r_wr;
  logic [7:0]  r_addr;
  logic        r_done;
  logic        r_err;
  logic        r_busy;
  logic [7:0]  r_cnt;

  logic [4:0]  w_sel_nxt;
  logic        w_wr_nxt;
  logic [7:0]  w_addr_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic [7:0]  w_cnt_nxt;

  logic [4:0]  w_dec_sel;
  logic        w_dec_valid;
  logic        w_hit;
  logic        w_last;

  bus_addr2sel #(
    .REGION_W (ADDR_W - 8)
  ) u_addr2sel (
    .i_region (m_addr[ADDR_W-1:8]),
    .o_sel    (w_dec_sel),
    .o_valid  (w_dec_valid)
  );

  // Only the selected slave's ready counts; strays on other slaves are ignored.
  assign w_hit  = |(s_ready & r_sel);
  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (m_req) begin
          w_next_state = w_dec_valid ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (w_hit || w_last) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt  = r_sel;
    w_wr_nxt   = r_wr;
    w_addr_nxt = r_addr;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sel_nxt = SEL_NONE;
        if (m_req) begin
          if (w_dec_valid) begin
            w_sel_nxt  = w_dec_sel;
            w_wr_nxt   = m_wr;
            w_addr_nxt = m_addr[7:0];
            w_cnt_nxt  = 8'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ready on the final allowed cycle wins over the timeout.
        if (w_hit) begin
          w_done_nxt = 1'b1;
          w_sel_nxt  = SEL_NONE;
          w_wr_nxt   = 1'b0;
        end else if (w_last) begin
          w_err_nxt = 1'b1;
          w_sel_nxt = SEL_NONE;
          w_wr_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      RESP: begin
        w_sel_nxt = SEL_NONE;
        w_wr_nxt  = 1'b0;
      end
      default: begin
        w_sel_nxt = SEL_NONE;
        w_wr_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel  <= SEL_NONE;
      r_wr   <= 1'b0;
      r_addr <= 8'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= 8'd0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_wr   <= w_wr_nxt;
      r_addr <= w_addr_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      r_busy <= (w_next_state != IDLE);
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign slave_sel = r_sel;
  assign s_wr      = r_wr;
  assign s_addr    = r_addr;
  assign m_done    = r_done;
  assign m_err     = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bus_addrdec.sv
// tb/tb_bus_addrdec.sv - table-driven scoreboard bench for bus_addrdec
module tb_bus_addrdec;

  logic        clk;
  logic        reset;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [4:0]  s_ready;
  logic [4:0]  slave_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic        m_done;
  logic        m_err;
  logic        busy;

  bus_addrdec #(
    .ADDR_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .s_ready   (s_ready),
    .slave_sel (slave_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .m_done    (m_done),
    .m_err     (m_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    int          rdy_at;
    logic [4:0]  rdy_val;
    logic [4:0]  wrong_val;
    logic [4:0]  exp_sel;
    logic [7:0]  exp_addr;
    logic        exp_wr;
    int          exp_cyc;
    logic        exp_done;
  } vec_t;

  typedef struct {
    logic [4:0] sel;
    logic [7:0] addr;
    logic       wr;
    int         cyc;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_pass;

  int         mon_sel_cnt;
  int         mon_busy_cnt;
  logic [4:0] mon_seen_sel;
  logic [7:0] mon_seen_addr;
  logic       mon_seen_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_sel_cnt   = 0;
      mon_busy_cnt  = 0;
      mon_seen_sel  = 5'b0;
      mon_seen_addr = 8'h0;
      mon_seen_wr   = 1'b0;
    end else begin
      if (busy) mon_busy_cnt++;
      if (slave_sel != 5'b0) begin
        mon_sel_cnt++;
        mon_seen_sel  = mon_seen_sel | slave_sel;
        mon_seen_addr = s_addr;
        mon_seen_wr   = s_wr;
      end
      if (m_done || m_err) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", m_done, m_err);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_err_exclusive", {31'b0, m_done & m_err}, 32'd0);
          check("m_done", {31'b0, m_done}, {31'b0, e.done});
          check("m_err", {31'b0, m_err}, {31'b0, !e.done});
          check("sel_cycles", mon_sel_cnt, e.cyc);
          check("busy_cycles", mon_busy_cnt, e.cyc + 1);
          check("sel_value", {27'b0, mon_seen_sel}, {27'b0, e.sel});
          if (e.cyc > 0) begin
            check("s_addr", {24'b0, mon_seen_addr}, {24'b0, e.addr});
            check("s_wr", {31'b0, mon_seen_wr}, {31'b0, e.wr});
          end
          check("resp_sel_clear", {27'b0, slave_sel}, 32'd0);
          check("resp_wr_clear", {31'b0, s_wr}, 32'd0);
        end
        mon_sel_cnt   = 0;
        mon_busy_cnt  = 0;
        mon_seen_sel  = 5'b0;
        mon_seen_addr = 8'h0;
        mon_seen_wr   = 1'b0;
      end
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t e;
    e.sel  = v.exp_sel;
    e.addr = v.exp_addr;
    e.wr   = v.exp_wr;
    e.cyc  = v.exp_cyc;
    e.done = v.exp_done;
    @(negedge clk);
    m_req   = 1'b1;
    m_addr  = v.addr;
    m_wr    = v.wr;
    s_ready = 5'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    m_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      s_ready = (v.rdy_at != 0 && k >= v.rdy_at) ? v.rdy_val : v.wrong_val;
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    s_ready = 5'b0;
    check("txn_complete", {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] done_seq;
    int         pulses;
    exp_t       eb;

    n_checks = 0;
    n_pass   = 0;

    //          addr      wr    rdy  rdy_val    wrong      sel        addr   wr    cyc done
    vecs[0]  = '{16'h0210, 1'b1, 1,  5'b00100, 5'b00000, 5'b00100, 8'h10, 1'b1, 1,  1'b1};
    vecs[1]  = '{16'h0705, 1'b0, 1,  5'b11111, 5'b00000, 5'b00000, 8'h00, 1'b0, 0,  1'b0};
    vecs[2]  = '{16'h0000, 1'b0, 0,  5'b00000, 5'b00000, 5'b10000, 8'h00, 1'b0, 15, 1'b0};
    vecs[3]  = '{16'h0400, 1'b1, 4,  5'b00001, 5'b01000, 5'b00001, 8'h00, 1'b1, 4,  1'b1};
    vecs[4]  = '{16'h03AB, 1'b0, 15, 5'b00010, 5'b00000, 5'b00010, 8'hAB, 1'b0, 15, 1'b1};
    vecs[5]  = '{16'h0155, 1'b1, 2,  5'b01000, 5'b00000, 5'b01000, 8'h55, 1'b1, 2,  1'b1};
    vecs[6]  = '{16'hFF00, 1'b1, 1,  5'b11111, 5'b00000, 5'b00000, 8'h00, 1'b0, 0,  1'b0};
    vecs[7]  = '{16'h0500, 1'b0, 1,  5'b11111, 5'b00000, 5'b00000, 8'h00, 1'b0, 0,  1'b0};
    vecs[8]  = '{16'h01C3, 1'b0, 3,  5'b11111, 5'b10111, 5'b01000, 8'hC3, 1'b0, 3,  1'b1};
    vecs[9]  = '{16'h04FE, 1'b1, 14, 5'b00001, 5'b11110, 5'b00001, 8'hFE, 1'b1, 14, 1'b1};
    vecs[10] = '{16'h0233, 1'b1, 16, 5'b00100, 5'b11011, 5'b00100, 8'h33, 1'b1, 15, 1'b0};
    vecs[11] = '{16'h1000, 1'b1, 1,  5'b11111, 5'b00000, 5'b00000, 8'h00, 1'b0, 0,  1'b0};

    reset   = 1'b1;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 16'h0;
    s_ready = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_slave_sel", {27'b0, slave_sel}, 32'd0);
    check("rst_s_wr", {31'b0, s_wr}, 32'd0);
    check("rst_s_addr", {24'b0, s_addr}, 32'd0);
    check("rst_m_done", {31'b0, m_done}, 32'd0);
    check("rst_m_err", {31'b0, m_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i]);
      repeat (2) @(posedge clk);
    end

    // Held request with ready already high: accepted every third edge.
    eb.sel  = 5'b00100;
    eb.addr = 8'h10;
    eb.wr   = 1'b1;
    eb.cyc  = 1;
    eb.done = 1'b1;
    @(negedge clk);
    sb_q.push_back(eb);
    sb_q.push_back(eb);
    m_req   = 1'b1;
    m_addr  = 16'h0210;
    m_wr    = 1'b1;
    s_ready = 5'b00100;
    done_seq = 6'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) m_req = 1'b0;
      done_seq[i] = m_done;
    end
    s_ready = 5'b0;
    check("b2b_done_pattern", {26'b0, done_seq}, {26'b0, 6'b010010});
    check("b2b_idle", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);

    // Reset during the second ACCESS cycle aborts silently.
    @(negedge clk);
    m_req   = 1'b1;
    m_addr  = 16'h0000;
    m_wr    = 1'b1;
    s_ready = 5'b0;
    @(posedge clk);
    #1;
    m_req = 1'b0;
    check("abort_sel_before", {27'b0, slave_sel}, {27'b0, 5'b10000});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_slave_sel", {27'b0, slave_sel}, 32'd0);
    check("abort_s_wr", {31'b0, s_wr}, 32'd0);
    check("abort_s_addr", {24'b0, s_addr}, 32'd0);
    check("abort_m_done", {31'b0, m_done}, 32'd0);
    check("abort_m_err", {31'b0, m_err}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m_done || m_err) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);

    run_txn('{16'h0100, 1'b0, 2, 5'b01000, 5'b00000, 5'b01000, 8'h00, 1'b0, 2, 1'b1});
    repeat (3) @(posedge clk);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
